// File: rtl/bk_adder_pipelined_if.sv
// ---------------------------------------------------------------------------
// bk_adder_pipelined_if
// Operand/result bundle for the pipelined Brent-Kung adder/subtractor.
//   in_valid/in_ready      : operand beat handshake (master -> slave)
//   operand_1, operand_2   : N_BIT-wide operands
//   carry_in, sub          : carry-in (ignored when subtracting), op select
//   out_valid/out_ready    : result beat handshake (slave -> master)
//   sum, carry_out, overflow : N_BIT result, raw carry out of MSB, signed ovf
// The master modport is the operand issuer / result consumer; the slave
// modport is the adder itself.
// ---------------------------------------------------------------------------
interface bk_adder_pipelined_if #(
   parameter int N_BIT = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [N_BIT-1:0] operand_1;
   logic [N_BIT-1:0] operand_2;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [N_BIT-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, operand_1, operand_2, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, operand_1, operand_2, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
endinterface

// File: rtl/bk_adder_pipelined.sv
// ---------------------------------------------------------------------------
// bk_adder_pipelined
// Pipelined valence-2 Brent-Kung adder/subtractor with valid/ready flow
// control on both sides.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears every valid bit and the
//          output data registers
//   bus  : bk_adder_pipelined_if slave modport (operands in, result out)
// Pipeline: S0 operand register -> up-sweep -> [optional mid register when
// PIPE_MID=1] -> down-sweep + sum -> output register. Latency 2 + PIPE_MID.
// Each stage loads when it is empty or the stage after it is loading, so
// bubbles collapse and in_ready is combinational from out_ready.
// ---------------------------------------------------------------------------
module bk_adder_pipelined #(
   parameter int N_BIT    = 32,
   parameter int PIPE_MID = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   bk_adder_pipelined_if.slave  bus
);
   localparam int LOG_N = $clog2(N_BIT);

   // Up-sweep level lvl combines bit i with bit i-2^lvl where i+1 is a
   // multiple of 2^(lvl+1).
   function automatic logic [N_BIT-1:0] up_mask(input int lvl);
      logic [N_BIT-1:0] m;
      m = {N_BIT{1'b0}};
      for (int i = 0; i < N_BIT; i++) begin
         if (((i + 1) % (2 << lvl)) == 0) m[i] = 1'b1;
         else                             m[i] = 1'b0;
      end
      return m;
   endfunction

   // Down-sweep level lvl fills bit i = j*2^(lvl+1) + 2^lvl - 1 (j >= 1)
   // from the already complete prefix at i-2^lvl.
   function automatic logic [N_BIT-1:0] down_mask(input int lvl);
      logic [N_BIT-1:0] m;
      m = {N_BIT{1'b0}};
      for (int i = 0; i < N_BIT; i++) begin
         if ((((i + 1) % (2 << lvl)) == (1 << lvl)) && ((i + 1) > (2 << lvl))) m[i] = 1'b1;
         else                                                                    m[i] = 1'b0;
      end
      return m;
   endfunction

   // S0 operand register
   logic             v0_q;
   logic [N_BIT-1:0] a0_q, b0_q, b0_d;
   logic             cin0_q, cin0_d;
   // handshake enables
   logic             en0_s, enm_s, en2_s;
   // S1 bit-level terms
   logic [N_BIT-1:0] p1_s, g1_s;
   // values entering the down-sweep (registered or pass-through)
   logic             mid_v_s, mid_cin_s;
   logic [N_BIT-1:0] mid_p_s, mid_g_s, mid_pp_s;
   // full prefix generate G[i:0]
   logic [N_BIT-1:0] pre_g_s;
   // output register
   logic             v2_q, cout_q, ovf_q, cout_d, ovf_d;
   logic [N_BIT-1:0] sum_q, sum_d;

   assign en2_s        = ~v2_q | bus.out_ready;
   assign en0_s        = ~v0_q | enm_s;
   assign bus.in_ready = en0_s;

   // Subtraction is a + ~b + 1, so invert b and force the carry-in.
   always_comb begin
      if (bus.sub) begin
         b0_d   = ~bus.operand_2;
         cin0_d = 1'b1;
      end else begin
         b0_d   = bus.operand_2;
         cin0_d = bus.carry_in;
      end
   end

   // S0 input register; data only captured on a real beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_q   <= 1'b0;
         a0_q   <= {N_BIT{1'b0}};
         b0_q   <= {N_BIT{1'b0}};
         cin0_q <= 1'b0;
      end else if (en0_s) begin
         v0_q <= bus.in_valid;
         if (bus.in_valid) begin
            a0_q   <= bus.operand_1;
            b0_q   <= b0_d;
            cin0_q <= cin0_d;
         end
      end
   end

   // Carry-in folded into bit 0 so G[i:0] directly equals carry into bit i+1.
   assign p1_s = a0_q ^ b0_q;
   assign g1_s = (a0_q & b0_q) | {{(N_BIT-1){1'b0}}, p1_s[0] & cin0_q};

   for (genvar l = 0; l < LOG_N; l++) begin : g_up
      localparam int               K    = 1 << l;
      localparam logic [N_BIT-1:0] MASK = up_mask(l);
      logic [N_BIT-1:0] gi_s, pi_s, go_s, po_s;
      if (l == 0) begin : g_first
         assign gi_s = g1_s;
         assign pi_s = p1_s;
      end else begin : g_next
         assign gi_s = g_up[l-1].go_s;
         assign pi_s = g_up[l-1].po_s;
      end
      // Masked bits merge with the group K positions below; others pass.
      assign go_s = gi_s | (pi_s & (gi_s << K) & MASK);
      assign po_s = pi_s & ((pi_s << K) | ~MASK);
   end

   if (PIPE_MID != 0) begin : g_mid_reg
      logic             v1_q, cin1_q, en1_s;
      logic [N_BIT-1:0] p1_q, g1_q, pp1_q;

      assign en1_s = ~v1_q | en2_s;
      assign enm_s = en1_s;

      // Mid register between up-sweep and down-sweep.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v1_q   <= 1'b0;
            cin1_q <= 1'b0;
            p1_q   <= {N_BIT{1'b0}};
            g1_q   <= {N_BIT{1'b0}};
            pp1_q  <= {N_BIT{1'b0}};
         end else if (en1_s) begin
            v1_q <= v0_q;
            if (v0_q) begin
               cin1_q <= cin0_q;
               p1_q   <= p1_s;
               g1_q   <= g_up[LOG_N-1].go_s;
               pp1_q  <= g_up[LOG_N-1].po_s;
            end
         end
      end

      assign mid_v_s   = v1_q;
      assign mid_cin_s = cin1_q;
      assign mid_p_s   = p1_q;
      assign mid_g_s   = g1_q;
      assign mid_pp_s  = pp1_q;
   end else begin : g_mid_wire
      assign enm_s     = en2_s;
      assign mid_v_s   = v0_q;
      assign mid_cin_s = cin0_q;
      assign mid_p_s   = p1_s;
      assign mid_g_s   = g_up[LOG_N-1].go_s;
      assign mid_pp_s  = g_up[LOG_N-1].po_s;
   end

   // Group P of a down-sweep target is untouched by later up-sweep levels,
   // so every down level reads the tree's P directly.
   for (genvar d = 0; d < LOG_N - 1; d++) begin : g_dn
      localparam int               L    = LOG_N - 2 - d;
      localparam int               K    = 1 << L;
      localparam logic [N_BIT-1:0] MASK = down_mask(L);
      logic [N_BIT-1:0] gi_s, go_s;
      if (d == 0) begin : g_first
         assign gi_s = mid_g_s;
      end else begin : g_next
         assign gi_s = g_dn[d-1].go_s;
      end
      assign go_s = gi_s | (mid_pp_s & (gi_s << K) & MASK);
   end

   assign pre_g_s = g_dn[LOG_N-2].go_s;

   // Sum and flags: c[0] = cin, c[i] = G[i-1:0].
   always_comb begin
      sum_d  = mid_p_s ^ {pre_g_s[N_BIT-2:0], mid_cin_s};
      cout_d = pre_g_s[N_BIT-1];
      ovf_d  = pre_g_s[N_BIT-1] ^ pre_g_s[N_BIT-2];
   end

   // Output register; holds its beat while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q   <= 1'b0;
         sum_q  <= {N_BIT{1'b0}};
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (en2_s) begin
         v2_q <= mid_v_s;
         if (mid_v_s) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign bus.out_valid = v2_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bk_adder_pipelined.sv
// ---------------------------------------------------------------------------
// tb_bk_adder_pipelined
// Drives a 32-bit/PIPE_MID=1 instance and an 8-bit/PIPE_MID=0 instance in
// lockstep from hand-computed vector tables. Each side keeps its own send and
// receive index; results are compared in order against the table.
// ---------------------------------------------------------------------------
module tb_bk_adder_pipelined;
   typedef struct packed {
      logic [31:0] a; logic [31:0] b; logic cin; logic sub;
      logic [31:0] s; logic co; logic ov;
   } v32_t;
   typedef struct packed {
      logic [7:0] a; logic [7:0] b; logic cin; logic sub;
      logic [7:0] s; logic co; logic ov;
   } v8_t;

   localparam int N32 = 10;
   localparam int N8  = 8;

   v32_t t32 [N32];
   v8_t  t8  [N8];

   logic clk = 1'b0;
   logic rst = 1'b0;

   bk_adder_pipelined_if #(.N_BIT(32)) bus32 ();
   bk_adder_pipelined_if #(.N_BIT(8))  bus8 ();

   bk_adder_pipelined #(.N_BIT(32), .PIPE_MID(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   bk_adder_pipelined #(.N_BIT(8),  .PIPE_MID(0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int sent32 = 0, got32 = 0, sent8 = 0, got8 = 0;
   int cyc = 0, first32 = -1, first8 = -1;
   bit hold32 = 1'b0, hold8 = 1'b0;
   logic [33:0] held32;
   logic [9:0]  held8;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle();
      chk("rst_valid32", 64'(bus32.out_valid), 64'd0);
      chk("rst_ready32", 64'(bus32.in_ready),  64'd1);
      chk("rst_sum32",   64'(bus32.sum),       64'd0);
      chk("rst_co32",    64'(bus32.carry_out), 64'd0);
      chk("rst_ov32",    64'(bus32.overflow),  64'd0);
      chk("rst_valid8",  64'(bus8.out_valid),  64'd0);
      chk("rst_ready8",  64'(bus8.in_ready),   64'd1);
      chk("rst_sum8",    64'(bus8.sum),        64'd0);
      chk("rst_co8",     64'(bus8.carry_out),  64'd0);
      chk("rst_ov8",     64'(bus8.overflow),   64'd0);
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input bit vin, input bit r);
      v32_t x32, e32;
      v8_t  x8, e8;
      bit   fin32, fin8;
      x32 = t32[sent32 % N32];
      x8  = t8[sent8 % N8];
      bus32.in_valid  = vin;   bus32.operand_1 = x32.a; bus32.operand_2 = x32.b;
      bus32.carry_in  = x32.cin; bus32.sub     = x32.sub; bus32.out_ready = r;
      bus8.in_valid   = vin;   bus8.operand_1  = x8.a;  bus8.operand_2  = x8.b;
      bus8.carry_in   = x8.cin; bus8.sub       = x8.sub; bus8.out_ready  = r;
      #1;
      if (hold32) chk("hold32", 64'({bus32.out_valid, bus32.carry_out, bus32.overflow, bus32.sum}),
                      64'({1'b1, held32}));
      if (hold8)  chk("hold8",  64'({bus8.out_valid, bus8.carry_out, bus8.overflow, bus8.sum}),
                      64'({1'b1, held8}));
      hold32 = bus32.out_valid & ~bus32.out_ready;
      held32 = {bus32.carry_out, bus32.overflow, bus32.sum};
      hold8  = bus8.out_valid & ~bus8.out_ready;
      held8  = {bus8.carry_out, bus8.overflow, bus8.sum};
      if (bus32.out_valid && bus32.out_ready) begin
         e32 = t32[got32 % N32];
         chk("res32", 64'({bus32.carry_out, bus32.overflow, bus32.sum}), 64'({e32.co, e32.ov, e32.s}));
         got32++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
         e8 = t8[got8 % N8];
         chk("res8", 64'({bus8.carry_out, bus8.overflow, bus8.sum}), 64'({e8.co, e8.ov, e8.s}));
         got8++;
      end
      if (bus32.out_valid && first32 < 0) first32 = cyc;
      if (bus8.out_valid && first8 < 0)   first8  = cyc;
      fin32 = bus32.in_valid & bus32.in_ready;
      fin8  = bus8.in_valid & bus8.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (fin32) sent32++;
      if (fin8)  sent8++;
      cyc++;
   endtask

   initial begin
      int s32, s8, g32, g8;
      logic [15:0] ipat, rpat;
      //               a             b             cin   sub   sum           co    ov
      t32[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      t32[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      t32[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      t32[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      t32[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
      t32[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      t32[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      t32[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
      t32[8] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      t32[9] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
      t8[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      t8[1]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      t8[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      t8[3]  = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
      t8[4]  = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
      t8[5]  = '{8'hA5, 8'hC3, 1'b1, 1'b0, 8'h69, 1'b1, 1'b1};
      t8[6]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      t8[7]  = '{8'h40, 8'hC0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

      bus32.in_valid = 1'b0; bus32.operand_1 = 32'h0; bus32.operand_2 = 32'h0;
      bus32.carry_in = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
      bus8.in_valid  = 1'b0; bus8.operand_1  = 8'h0;  bus8.operand_2  = 8'h0;
      bus8.carry_in  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b0;

      // power-on reset
      #1 rst = 1'b1;
      #2 chk_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // single beat: latency 3 (PIPE_MID=1) and 2 (PIPE_MID=0)
      cyc = 0; first32 = -1; first8 = -1;
      cycle(1'b1, 1'b1);
      repeat (5) cycle(1'b0, 1'b1);
      chk("lat32", 64'(first32), 64'd3);
      chk("lat8",  64'(first8),  64'd2);
      chk("lat_cnt32", 64'(got32), 64'd1);
      chk("lat_cnt8",  64'(got8),  64'd1);

      // backpressure: capacity equals latency
      s32 = sent32; s8 = sent8;
      repeat (5) cycle(1'b1, 1'b0);
      chk("bp_acc32", 64'(sent32 - s32), 64'd3);
      chk("bp_acc8",  64'(sent8 - s8),   64'd2);
      chk("bp_rdy32", 64'(bus32.in_ready), 64'd0);
      chk("bp_rdy8",  64'(bus8.in_ready),  64'd0);
      g32 = got32; g8 = got8;
      repeat (3) cycle(1'b0, 1'b1);
      chk("bp_drain32", 64'(got32 - g32), 64'd3);
      chk("bp_drain8",  64'(got8 - g8),   64'd2);

      // reset with two beats in flight
      repeat (2) cycle(1'b1, 1'b0);
      bus32.in_valid = 1'b0; bus8.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_idle();
      @(negedge clk);
      rst = 1'b0;
      got32 = sent32; got8 = sent8; hold32 = 1'b0; hold8 = 1'b0;
      repeat (6) cycle(1'b0, 1'b1);
      chk("flush32", 64'(got32), 64'(sent32));
      chk("flush8",  64'(got8),  64'(sent8));

      // streaming with irregular valid/ready patterns
      ipat = 16'b1101_1011_0110_1111;
      rpat = 16'b1011_0010_1110_0101;
      s32 = sent32;
      for (int i = 0; i < 64; i++) cycle(ipat[i % 16], rpat[(i * 3) % 16]);
      repeat (8) cycle(1'b0, 1'b1);
      chk("stream_done32", 64'(got32), 64'(sent32));
      chk("stream_done8",  64'(got8),  64'(sent8));
      chk("stream_some32", 64'(sent32 - s32 > 20), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bk_adder_pipelined.md
# bk_adder_pipelined

Parametrised, pipelined Brent-Kung (valence-2) adder/subtractor with valid/ready flow control on both sides. It computes single-bit propagate/generate terms, the Brent-Kung up-sweep/down-sweep carry tree and the final sum. Registered pipeline boundaries give sustained throughput of one operation per cycle. It is the datapath-ready successor of the combinational PG/prefix adder blocks and sits between operand-issue logic and any consumer that may stall.

## Interface
Parameters:
- N_BIT, 32, operand width; power of two, 4 to 128.
- PIPE_MID, 1, 1 inserts a register between up-sweep and down-sweep; 0 omits it.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- operand_1  input  N_BIT  first operand.
- operand_2  input  N_BIT  second operand.
- carry_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  1: operand_1 − operand_2; 0: operand_1 + operand_2 + carry_in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N_BIT  result.
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.

## Operation
- Stage S0, the input register, captures operand_1, operand_2 ^ {N_BIT{sub}}, effective carry-in (sub ? 1 : carry_in) and a valid bit on an accepted beat (in_valid & in_ready).
- Stage S1 computes p = a ^ b and g = a & b per bit, folds the carry-in into bit 0 (g0' = g0 | p0&cin), then runs the up-sweep over log2(N_BIT) levels.
  - With PIPE_MID=1, S1 registers p, the partial group (G,P) tree and a valid bit.
  - With PIPE_MID=0, S1 passes its results combinationally to S2.
- Stage S2 runs the down-sweep over log2(N_BIT)−1 levels. It then computes sum[i] = p[i] ^ c[i], with c[0] = cin and c[i] = G[i−1:0].
  - carry_out = G[N_BIT−1:0].
  - overflow = c[N_BIT] ^ c[N_BIT−1].
  - S2 registers sum, carry_out, overflow and valid as the output register.
- Each pipeline register k holds a valid bit v_k and loads when en_k = !v_k | ready_{k+1}. The output stage uses ready = out_ready.
  - Bubbles collapse: an empty register accepts even while downstream is stalled.
  - in_ready = en_S0. It is allowed to be combinational from out_ready.
- While a stage is stalled (v_k=1, en_k=0), its data holds stable. Output data is stable while out_valid=1 and out_ready=0.
- Data registers of invalid stages may hold stale values. Outputs are qualified only by out_valid.
- Arithmetic is modulo 2^N_BIT.
  - Subtraction is a + ~b + 1.
  - carry_out follows raw carry semantics and is not inverted to a borrow.

## Timing
- Reset (async assert, released synchronously by the environment): all valid bits 0.
  - sum, carry_out and overflow read 0.
  - in_ready reads 1.
- Latency from accept edge to out_valid high is LAT = 2 + PIPE_MID cycles. A beat accepted at edge t appears with out_valid=1 after edge t+LAT−1. LAT = 3 for defaults.
- Throughput is 1 beat/cycle while out_ready=1.
- Capacity is LAT beats. With out_ready=0 held, in_ready drops after LAT accepted beats.
- Simultaneous accept at S0 and drain at the output in a full pipeline is allowed. Occupancy is unchanged and no beat is lost or duplicated.
- out_ready high with out_valid low has no effect.
- Reset mid-operation flushes all in-flight beats. No result of a pre-reset beat ever appears after reset.
- Ordering is strictly FIFO. Beats never reorder or merge.

## Test plan
- Reset, defaults: assert rst mid-stream with 2 beats in flight → out_valid=0, in_ready=1, sum=0 immediately; after release, no stale beat emerges.
- Add: operand_1=32'hFFFF_FFFF, operand_2=32'h0000_0001, carry_in=0, sub=0, out_ready=1 → 3 cycles later sum=0, carry_out=1, overflow=0.
- Sub/overflow: 32'h8000_0000 − 32'h0000_0001 → sum=32'h7FFF_FFFF, carry_out=1, overflow=1. Then 5 − 7 → sum=32'hFFFF_FFFE, carry_out=0, overflow=0.
- Backpressure: out_ready=0, stream 5 beats → exactly 3 accepted, in_ready=0. Raise out_ready → results emerge in order, held stable while stalled, one per cycle.
- Streaming: 1000 random beats with random in_valid/out_ready for N_BIT=8/PIPE_MID=0 and N_BIT=64/PIPE_MID=1 → results match the scoreboard (a+b+cin or a−b), with correct carry_out/overflow and no loss, duplication or reorder.
- Carry chain: operand_1=32'h7FFF_FFFF, operand_2=0, carry_in=1 → sum=32'h8000_0000, overflow=1, carry_out=0.
